// File: rtl/retire_trace_buffer.sv
// rtl/retire_trace_buffer.sv - retirement trace capture: two-step capture pipeline feeding a show-ahead FIFO
module retire_trace_buffer #(
    parameter int DEPTH      = 8,
    parameter int FILTER_NOP = 1,
    parameter int CNT_W      = 16
) (
    input  logic                       clock_i,
    input  logic                       rst_ni,
    input  logic                       enable_i,
    input  logic                       clear_i,
    input  logic                       retire_i,
    input  logic [31:0]                retire_instr_i,
    input  logic [15:0]                instr_addr_i,
    input  logic [7:0][31:0]           regfile_i,
    output logic                       trace_valid_o,
    input  logic                       trace_ready_i,
    output logic [2*CNT_W+63:0]        trace_data_o,
    output logic [$clog2(DEPTH):0]     fill_o,
    output logic [CNT_W-1:0]           overflow_cnt_o
);

    localparam int AW     = $clog2(DEPTH);
    localparam int PTR_W  = AW + 1;
    localparam int DATA_W = 2*CNT_W + 64;

    logic              a_valid;
    logic [31:0]       a_instr;
    logic [15:0]       a_pc;
    logic [CNT_W-1:0]  seq;
    logic [CNT_W-1:0]  ovf;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              capture;
    logic              empty;
    logic              full;
    logic              push;
    logic              pop;
    logic              push_ok;
    logic [31:0]       result;
    logic [DATA_W-1:0] entry;

    assign capture = retire_i & enable_i &
                     !((FILTER_NOP != 0) && (retire_instr_i[31:24] == 8'h00));

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop     = !empty & trace_ready_i;
    assign push    = a_valid;
    // When full, a simultaneous pop frees the very slot the push writes into.
    assign push_ok = push & (!full | pop);

    // Stage B is combinational: the write-back value is visible one cycle after retirement.
    assign result  = regfile_i[a_instr[18:16]];
    assign entry   = DATA_W'({seq, a_pc, a_instr, result});

    always_ff @(posedge clock_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_valid <= 1'b0;
            a_instr <= '0;
            a_pc    <= '0;
            seq     <= '0;
            ovf     <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
        end else if (clear_i) begin
            a_valid <= 1'b0;
            seq     <= '0;
            ovf     <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
        end else begin
            a_valid <= capture;
            if (capture) begin
                a_instr <= retire_instr_i;
                a_pc    <= instr_addr_i;
            end
            if (push) begin
                seq <= seq + CNT_W'(1);
                if (!push_ok && (ovf != '1)) begin
                    ovf <= ovf + CNT_W'(1);
                end
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (push_ok && !clear_i) begin
            mem[wr_ptr[AW-1:0]] <= entry;
        end
    end

    assign trace_valid_o  = !empty;
    assign trace_data_o   = empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign fill_o         = wr_ptr - rd_ptr;
    assign overflow_cnt_o = ovf;

endmodule

// File: tb/tb_retire_trace_buffer.sv
// tb/tb_retire_trace_buffer.sv - directed self-checking bench for retire_trace_buffer
module tb_retire_trace_buffer;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              enable;
    logic              clear;
    logic              retire;
    logic [31:0]       instr;
    logic [15:0]       pc;
    logic [7:0][31:0]  regfile;
    logic              valid;
    logic              ready;
    logic [95:0]       data;
    logic [3:0]        fill;
    logic [15:0]       ovf;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    retire_trace_buffer #(.DEPTH(8), .FILTER_NOP(1), .CNT_W(16)) dut (
        .clock_i        (clk),
        .rst_ni         (rst_n),
        .enable_i       (enable),
        .clear_i        (clear),
        .retire_i       (retire),
        .retire_instr_i (instr),
        .instr_addr_i   (pc),
        .regfile_i      (regfile),
        .trace_valid_o  (valid),
        .trace_ready_i  (ready),
        .trace_data_o   (data),
        .fill_o         (fill),
        .overflow_cnt_o (ovf)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [95:0] mk(input logic [15:0] s, input logic [15:0] p,
                                       input logic [31:0] i, input logic [31:0] r);
        return {s, p, i, r};
    endfunction

    task automatic do_retire(input logic [15:0] p, input logic [31:0] i);
        retire = 1'b1;
        pc     = p;
        instr  = i;
        step();
        retire = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        enable  = 1'b1;
        clear   = 1'b0;
        retire  = 1'b0;
        instr   = '0;
        pc      = '0;
        regfile = '0;
        ready   = 1'b0;
        #2;
        check("reset_valid", 96'(valid), 96'(0));
        check("reset_fill",  96'(fill),  96'(0));
        check("reset_ovf",   96'(ovf),   96'(0));
        check("reset_data",  data,       96'(0));
        step();
        rst_n = 1'b1;

        // 1: single retirement, result sampled one cycle later
        do_retire(16'h0010, 32'h01030102);
        regfile[3] = 32'd5;
        check("t1_valid_early", 96'(valid), 96'(0));
        step();
        check("t1_valid", 96'(valid), 96'(1));
        check("t1_data",  data, mk(16'd0, 16'h0010, 32'h01030102, 32'd5));
        check("t1_fill",  96'(fill), 96'(1));
        ready = 1'b1;
        step();
        ready = 1'b0;
        check("t1_popped_valid", 96'(valid), 96'(0));
        check("t1_popped_data",  data, 96'(0));

        // 2: NOP filtered, no sequence gap
        do_clear();
        regfile[1] = 32'h77;
        do_retire(16'h0020, 32'h00000000);
        do_retire(16'h0024, 32'h02010007);
        step();
        check("t2_fill", 96'(fill), 96'(1));
        check("t2_data", data, mk(16'd0, 16'h0024, 32'h02010007, 32'h77));

        // 3: ten back-to-back retirements into a stalled 8-deep FIFO
        do_clear();
        regfile[2] = 32'hA5;
        retire = 1'b1;
        instr  = 32'h01020000;
        for (int i = 0; i < 10; i++) begin
            pc = 16'h0100 + 16'(i);
            step();
        end
        retire = 1'b0;
        step();
        check("t3_fill", 96'(fill), 96'(8));
        check("t3_ovf",  96'(ovf),  96'(2));
        ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("t3_drain%0d", k), data,
                  mk(16'(k), 16'h0100 + 16'(k), 32'h01020000, 32'hA5));
            step();
        end
        ready = 1'b0;
        check("t3_empty_valid", 96'(valid), 96'(0));
        check("t3_empty_fill",  96'(fill),  96'(0));

        // 4: full FIFO with push and pop every cycle; seq continues from 10
        retire = 1'b1;
        for (int j = 0; j < 8; j++) begin
            pc = 16'h0100 + 16'(j);
            step();
        end
        pc = 16'h0200;
        step();
        check("t4_full_fill", 96'(fill), 96'(8));
        check("t4_full_ovf",  96'(ovf),  96'(2));
        ready = 1'b1;
        for (int j = 1; j < 7; j++) begin
            pc = 16'h0200 + 16'(j);
            step();
            check($sformatf("t4_fill%0d", j), 96'(fill), 96'(8));
            check($sformatf("t4_head%0d", j), 96'(data[95:80]), 96'(10 + j));
        end
        retire = 1'b0;
        step();
        check("t4_last_fill", 96'(fill), 96'(8));
        check("t4_last_ovf",  96'(ovf),  96'(2));
        check("t4_head17", data[95:64], {16'd17, 16'h0107});
        step();
        for (int j = 0; j < 7; j++) begin
            check($sformatf("t4_drain%0d", j), data[95:64], {16'(18 + j), 16'h0200 + 16'(j)});
            step();
        end
        ready = 1'b0;
        check("t4_drained_fill", 96'(fill), 96'(0));

        // 5: clear with fill=5 and an entry in flight
        retire = 1'b1;
        for (int i = 0; i < 5; i++) begin
            pc = 16'h0500 + 16'(i);
            step();
        end
        retire = 1'b0;
        step();
        check("t5_fill5", 96'(fill), 96'(5));
        check("t5_ovf_pre", 96'(ovf), 96'(2));
        do_retire(16'h05AA, 32'h01020000);
        retire = 1'b1;
        pc     = 16'h05BB;
        ready  = 1'b1;
        do_clear();
        retire = 1'b0;
        ready  = 1'b0;
        check("t5_clr_fill",  96'(fill),  96'(0));
        check("t5_clr_valid", 96'(valid), 96'(0));
        check("t5_clr_ovf",   96'(ovf),   96'(0));
        step();
        check("t5_clr_fill2", 96'(fill), 96'(0));
        do_retire(16'h05CC, 32'h01020000);
        step();
        check("t5_seq0", data, mk(16'd0, 16'h05CC, 32'h01020000, 32'hA5));

        // 6: asynchronous reset in the middle of a drain
        retire = 1'b1;
        for (int j = 0; j < 6; j++) begin
            ready = j[0];
            pc    = 16'h0600 + 16'(j);
            step();
        end
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 96'(valid), 96'(0));
        check("t6_rst_fill",  96'(fill),  96'(0));
        check("t6_rst_ovf",   96'(ovf),   96'(0));
        check("t6_rst_data",  data,       96'(0));
        retire = 1'b0;
        ready  = 1'b0;
        step();
        #2;
        rst_n = 1'b1;
        step();
        do_retire(16'h0680, 32'h01030102);
        step();
        check("t6_resume", data, mk(16'd0, 16'h0680, 32'h01030102, 32'd5));

        // 7: disabling capture lets the in-flight entry finish
        do_retire(16'h0700, 32'h01030102);
        enable = 1'b0;
        do_retire(16'h0704, 32'h01030102);
        step();
        enable = 1'b1;
        check("t7_fill", 96'(fill), 96'(2));
        ready = 1'b1;
        step();
        check("t7_head", data, mk(16'd1, 16'h0700, 32'h01030102, 32'd5));
        step();
        ready = 1'b0;
        check("t7_empty", 96'(valid), 96'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
